// File: rtl/jt12_div_ctrl.sv
// -----------------------------------------------------------------------------
// jt12_div_ctrl
// Single-clock prescaler controller for the JT12 FM core. The YM2612 prescaler
// registers 0x2D/0x2E/0x2F select a master-clock divide ratio of 6/3/2. Instead
// of generating divided clocks, the ratio is turned into a one-cycle clock
// enable (cen). Ratio changes are only applied at a period boundary, so no
// divide period is ever shortened or stretched. The block also generates the
// internal synchronous reset and the operator-slot sequencer with its
// per-sample strobe.
//
// Ports:
//   clk      master clock
//   rst_n    asynchronous active-low reset
//   cs_n     chip select, active low
//   wr_n     write strobe, active low; a write is taken on its falling edge
//   addr     addr[0]: 0 = register-number latch, 1 = data; addr[1]=1 ignored
//   din      write data
//   cen      one-cycle clock enable, one pulse per divide period
//   div_sel  active ratio: 0 = /6, 1 = /3, 2 = /2
//   busy     a ratio change is waiting for the next period boundary
//   rst_int  synchronous internal reset, active high
//   slot     current operator slot, 0..SLOTS-1
//   smp      sample strobe, coincident with cen on the slot wrap
// -----------------------------------------------------------------------------
module jt12_div_ctrl #(
    parameter int SLOTS   = 24,
    parameter int RST_CEN = 2,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic       cen,
    output logic [1:0] div_sel,
    output logic       busy,
    output logic       rst_int,
    output logic [4:0] slot,
    output logic       smp
);

    localparam int RST_W = (RST_CEN < 2) ? 1 : $clog2(RST_CEN);

    localparam logic [1:0]       DIV6      = 2'd0;
    localparam logic [1:0]       DIV3      = 2'd1;
    localparam logic [1:0]       DIV2      = 2'd2;
    localparam logic [4:0]       SLOT_LAST = 5'(SLOTS - 1);
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CEN - 1);

    logic             wr_q;
    logic [7:0]       reg_num;
    logic [1:0]       pend;
    logic [CNT_W-1:0] cnt;
    logic [RST_W-1:0] rst_cnt;

    logic [CNT_W-1:0] div_n;
    logic             wrap;
    logic             wr_ev;
    logic             req_vld;
    logic [1:0]       req;
    logic [1:0]       div_nx;
    logic             pend_nx;
    logic             rst_int_nx;
    logic [4:0]       slot_nx;

    // Next-state helpers shared by both register blocks.
    // div_nx/pend_nx describe the ratio state just after this edge's boundary
    // handling, so a request arriving on a wrap edge is judged against the
    // ratio that is about to become active, not the one being retired.
    // rst_int_nx/slot_nx give the values the next cycle will see, which lets
    // smp be registered and still line up with the cen cycle it marks.
    always_comb begin
        div_n = CNT_W'(6);
        case (div_sel)
            DIV3:    div_n = CNT_W'(3);
            DIV2:    div_n = CNT_W'(2);
            default: div_n = CNT_W'(6);
        endcase

        wrap  = (cnt == div_n - 1'b1);
        wr_ev = wr_q & ~wr_n & ~cs_n;

        req_vld = 1'b0;
        req     = DIV6;
        if (wr_ev && addr == 2'b01) begin
            case (reg_num)
                8'h2D: begin
                    req_vld = 1'b1;
                    req     = DIV6;
                end
                8'h2E: begin
                    req_vld = 1'b1;
                    req     = DIV3;
                end
                8'h2F: begin
                    req_vld = 1'b1;
                    req     = DIV2;
                end
                default: begin
                    req_vld = 1'b0;
                    req     = DIV6;
                end
            endcase
        end

        div_nx  = (wrap && busy) ? pend : div_sel;
        pend_nx = busy & ~wrap;

        rst_int_nx = rst_int & ~(cen && rst_cnt == RST_LAST);

        slot_nx = slot;
        if (cen && !rst_int) begin
            slot_nx = (slot == SLOT_LAST) ? 5'd0 : slot + 5'd1;
        end
    end

    // Write decoding, divide counter and ratio switching.
    // The counter restarts at 0 on every wrap; cen is simply the registered
    // wrap, so it is high in the first cycle of each period. A pending ratio
    // is only moved into div_sel on a wrap edge, which makes the new period
    // start cleanly at cnt=0 with the new length. A request equal to the
    // active ratio is dropped unless something is already pending, in which
    // case it overwrites the pending ratio and completes as a no-op switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b1;
            reg_num <= 8'h00;
            cnt     <= '0;
            cen     <= 1'b0;
            div_sel <= DIV6;
            pend    <= DIV6;
            busy    <= 1'b0;
        end else begin
            wr_q <= wr_n;
            if (wr_ev && addr == 2'b00) begin
                reg_num <= din;
            end
            cnt     <= wrap ? '0 : cnt + 1'b1;
            cen     <= wrap;
            div_sel <= div_nx;
            if (req_vld && (pend_nx || req != div_nx)) begin
                pend <= req;
                busy <= 1'b1;
            end else begin
                busy <= pend_nx;
            end
        end
    end

    // Internal reset and operator-slot sequencer.
    // rst_int counts cen cycles after reset release and drops on the edge
    // that ends the RST_CEN-th one. The slot counter only moves once rst_int
    // is low, advancing at the end of every cen cycle; smp flags the cen
    // cycle spent in the last slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_int <= 1'b1;
            rst_cnt <= '0;
            slot    <= 5'd0;
            smp     <= 1'b0;
        end else begin
            rst_int <= rst_int_nx;
            if (rst_int && cen && rst_cnt != RST_LAST) begin
                rst_cnt <= rst_cnt + 1'b1;
            end
            slot <= slot_nx;
            smp  <= wrap && (slot_nx == SLOT_LAST) && !rst_int_nx;
        end
    end

endmodule

// File: tb/tb_jt12_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jt12_div_ctrl
// Self-checking bench for jt12_div_ctrl. A behavioural model tracks the
// prescaler in terms of period start times, cen counts and slot counts and is
// compared against every DUT output on every clock and on reset assertion.
// Directed table vectors and hand-written sequences cover the ratio-switch
// corner cases; a randomized phase exercises writes and resets at random.
// -----------------------------------------------------------------------------
module tb_jt12_div_ctrl;

    localparam int SLOTS   = 24;
    localparam int RST_CEN = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n  = 1'b1;
    logic       wr_n  = 1'b1;
    logic [1:0] addr  = 2'b00;
    logic [7:0] din   = 8'h00;

    logic       cen;
    logic [1:0] div_sel;
    logic       busy;
    logic       rst_int;
    logic [4:0] slot;
    logic       smp;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_on = 1'b0;

    jt12_div_ctrl #(
        .SLOTS   (SLOTS),
        .RST_CEN (RST_CEN),
        .CNT_W   (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs_n    (cs_n),
        .wr_n    (wr_n),
        .addr    (addr),
        .din     (din),
        .cen     (cen),
        .div_sel (div_sel),
        .busy    (busy),
        .rst_int (rst_int),
        .slot    (slot),
        .smp     (smp)
    );

    // Free-running 10 ns master clock.
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Behavioural model: the current period is described by its start cycle
    // and the length implied by the active ratio; cen fires whenever a new
    // period begins. rst_int and slot are derived from how many cen cycles
    // have completed.
    // -------------------------------------------------------------------------
    int         m_t;
    int         m_start;
    int         m_cens;
    int         m_adv;
    logic [1:0] m_div;
    logic [1:0] m_pend;
    logic       m_busy;
    logic       m_wrq;
    logic       m_cen;
    logic       m_rst;
    logic       m_smp;
    logic [7:0] m_latch;
    logic [4:0] m_slot;

    function automatic int periodLen(input logic [1:0] d);
        case (d)
            2'd1:    return 3;
            2'd2:    return 2;
            default: return 6;
        endcase
    endfunction

    function automatic void modelReset();
        m_t     = 0;
        m_start = 0;
        m_cens  = 0;
        m_adv   = 0;
        m_div   = 2'd0;
        m_pend  = 2'd0;
        m_busy  = 1'b0;
        m_wrq   = 1'b1;
        m_cen   = 1'b0;
        m_rst   = 1'b1;
        m_smp   = 1'b0;
        m_latch = 8'h00;
        m_slot  = 5'd0;
    endfunction

    function automatic void modelStep();
        logic       prev_cen;
        logic       prev_rst;
        logic       wrapped;
        logic       ev;
        logic       req_ok;
        logic [1:0] req;
        prev_cen = m_cen;
        prev_rst = m_rst;
        m_t++;
        if (prev_cen) begin
            m_cens++;
            if (!prev_rst) m_adv++;
        end
        m_rst   = (m_cens < RST_CEN);
        wrapped = (m_t == m_start + periodLen(m_div));
        ev      = m_wrq && !wr_n && !cs_n;
        m_wrq   = wr_n;
        req_ok  = 1'b0;
        req     = 2'd0;
        if (ev && addr == 2'b01 && m_latch >= 8'h2D && m_latch <= 8'h2F) begin
            req_ok = 1'b1;
            req    = 2'(m_latch - 8'h2D);
        end
        if (ev && addr == 2'b00) m_latch = din;
        if (wrapped) begin
            m_start = m_t;
            if (m_busy) begin
                m_div  = m_pend;
                m_busy = 1'b0;
            end
        end
        if (req_ok && (m_busy || req != m_div)) begin
            m_pend = req;
            m_busy = 1'b1;
        end
        m_cen  = wrapped;
        m_slot = 5'(m_adv % SLOTS);
        m_smp  = wrapped && (m_slot == 5'(SLOTS - 1)) && !m_rst;
    endfunction

    // -------------------------------------------------------------------------
    // Comparison helper: counts every comparison and reports each mismatch.
    // -------------------------------------------------------------------------
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous model check: advance the model on each clock edge (or reset
    // it on reset assertion) and compare all outputs 1 ns later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelReset();
        else        modelStep();
        #1;
        if (chk_on) begin
            checkOutput("model cycle",
                        {21'd0, cen, div_sel, busy, rst_int, slot, smp},
                        {21'd0, m_cen, m_div, m_busy, m_rst, m_slot, m_smp});
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    // One write event: wr_n low for one cycle then high for one cycle.
    // b_after is busy sampled half a cycle after the event edge.
    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d,
                                 output logic b_after);
        @(negedge clk);
        cs_n = 1'b0;
        addr = a;
        din  = d;
        wr_n = 1'b0;
        @(negedge clk);
        b_after = busy;
        wr_n = 1'b1;
        cs_n = 1'b1;
    endtask

    task automatic writeReg(input logic [7:0] regno, input logic part,
                            output logic b_after);
        logic b0;
        applyStimulus({part, 1'b0}, regno, b0);
        applyStimulus({part, 1'b1}, 8'h00, b_after);
    endtask

    task automatic waitCen(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!cen && n < 40);
    endtask

    task automatic waitSmp(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!smp && n < 400);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("busy clears", busy, 0);
    endtask

    // Startup after reset release: /6, first cen 6 cycles in, rst_int held
    // through two cen pulses, optionally the smp cadence.
    task automatic checkStartup(input bit do_smp);
        int n;
        waitCen(n);
        checkOutput("first cen delay", n, 6);
        checkOutput("div after reset", div_sel, 0);
        checkOutput("busy after reset", busy, 0);
        checkOutput("rst_int at 1st cen", rst_int, 1);
        waitCen(n);
        checkOutput("second cen spacing", n, 6);
        checkOutput("rst_int at 2nd cen", rst_int, 1);
        @(posedge clk);
        #1;
        checkOutput("rst_int released", rst_int, 0);
        checkOutput("slot held at 0", slot, 0);
        if (do_smp) begin
            waitSmp(n);
            checkOutput("first smp delay", n, 143);
            checkOutput("slot at smp", slot, 23);
            checkOutput("cen with smp", cen, 1);
            waitSmp(n);
            checkOutput("smp spacing", n, 144);
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed vectors: register written, busy right after the data write,
    // ratio and cen spacing once the change has settled.
    // -------------------------------------------------------------------------
    typedef struct {
        logic [7:0] regno;
        logic       part;
        logic       exp_busy;
        logic [1:0] exp_div;
        int         exp_len;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   n;
        logic b;

        vecs.push_back('{8'h2D, 1'b0, 1'b0, 2'd0, 6});
        vecs.push_back('{8'h28, 1'b0, 1'b0, 2'd0, 6});
        vecs.push_back('{8'h2F, 1'b0, 1'b1, 2'd2, 2});
        vecs.push_back('{8'h2E, 1'b0, 1'b1, 2'd1, 3});
        vecs.push_back('{8'h2E, 1'b0, 1'b0, 2'd1, 3});
        vecs.push_back('{8'h2D, 1'b0, 1'b1, 2'd0, 6});
        vecs.push_back('{8'h2F, 1'b0, 1'b1, 2'd2, 2});
        vecs.push_back('{8'h2D, 1'b1, 1'b0, 2'd2, 2});

        $display("[TB] reset and startup");
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        rst_n  = 1'b1;
        checkStartup(1'b1);

        $display("[TB] directed ratio vectors");
        foreach (vecs[i]) begin
            writeReg(vecs[i].regno, vecs[i].part, b);
            checkOutput("vec busy", b, vecs[i].exp_busy);
            waitIdle();
            waitCen(n);
            waitCen(n);
            checkOutput("vec period", n, vecs[i].exp_len);
            checkOutput("vec div", div_sel, vecs[i].exp_div);
        end

        $display("[TB] reset while a change is pending in /2");
        applyStimulus(2'b00, 8'h2D, b);
        @(negedge clk);
        cs_n = 1'b0;
        addr = 2'b01;
        din  = 8'h00;
        wr_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pending before reset", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset cen", cen, 0);
        checkOutput("async reset div", div_sel, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset rst_int", rst_int, 1);
        checkOutput("async reset slot", slot, 0);
        checkOutput("async reset smp", smp, 0);
        wr_n = 1'b1;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkStartup(1'b0);

        $display("[TB] pending /3 overwritten by /2");
        applyStimulus(2'b00, 8'h2E, b);
        waitCen(n);
        applyStimulus(2'b01, 8'h00, b);
        checkOutput("overwrite first pend", b, 1);
        applyStimulus(2'b00, 8'h2F, b);
        applyStimulus(2'b01, 8'h00, b);
        @(posedge clk);
        #1;
        checkOutput("overwrite boundary cen", cen, 1);
        checkOutput("overwrite div", div_sel, 2);
        checkOutput("overwrite busy", busy, 0);
        waitCen(n);
        checkOutput("overwrite no /3 period", n, 2);

        writeReg(8'h2D, 1'b0, b);
        waitIdle();

        $display("[TB] write on the wrap edge while /3 is pending");
        applyStimulus(2'b00, 8'h2E, b);
        waitCen(n);
        applyStimulus(2'b01, 8'h00, b);
        applyStimulus(2'b00, 8'h2F, b);
        @(negedge clk);
        @(negedge clk);
        cs_n = 1'b0;
        addr = 2'b01;
        din  = 8'h00;
        wr_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("wrap-edge cen", cen, 1);
        checkOutput("wrap-edge div", div_sel, 1);
        checkOutput("wrap-edge busy", busy, 1);
        @(negedge clk);
        wr_n = 1'b1;
        cs_n = 1'b1;
        waitCen(n);
        checkOutput("wrap-edge /3 period", n, 3);
        checkOutput("wrap-edge later div", div_sel, 2);
        checkOutput("wrap-edge later busy", busy, 0);

        $display("[TB] wr_n held low for 10 cycles");
        @(negedge clk);
        cs_n = 1'b0;
        addr = 2'b00;
        din  = 8'h2E;
        wr_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            din = (i % 2 == 1) ? 8'h2F : 8'h28;
        end
        wr_n = 1'b1;
        cs_n = 1'b1;
        applyStimulus(2'b01, 8'h00, b);
        checkOutput("held-low single latch", b, 1);
        waitIdle();
        waitCen(n);
        waitCen(n);
        checkOutput("held-low period", n, 3);
        checkOutput("held-low div", div_sel, 1);

        $display("[TB] randomized writes and resets");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            cs_n  = ($urandom_range(0, 3) == 0);
            wr_n  = 1'($urandom_range(0, 1));
            addr  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       din = 8'h2D;
                1:       din = 8'h2E;
                2:       din = 8'h2F;
                3:       din = 8'h28;
                default: din = 8'($urandom);
            endcase
        end
        @(negedge clk);
        rst_n = 1'b1;
        cs_n  = 1'b1;
        wr_n  = 1'b1;
        repeat (5) @(posedge clk);
        #3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
